// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one synchronous memory bus between the instruction-fetch port (i_*)
//   and the MEM-stage data port (d_*). Each request becomes a single registered
//   bus transaction. The requester is stalled until that transaction is acked.
//   A completed result is latched with a done flag. The flag holds while the
//   pipeline is frozen, so a completed access is never reissued. A fetch that
//   is in flight when a flush arrives still completes on the bus, but its
//   result is thrown away.
//
//   Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
//   ports are pending. Without it, the data port always wins.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   pipe_stall, flush         pipeline controller status
//   i_ce/i_addr               fetch request; i_rdata/i_stall fetch result/stall
//   d_ce/d_we/d_sel/d_addr/d_wdata   data request; d_rdata/d_stall result/stall
//   stallreq                  i_stall | d_stall, to the pipeline controller
//   bus_stb/we/sel/addr/wdata registered bus request
//   bus_rdata/bus_ack         bus response (ack is a one-cycle pulse)
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_stall,
  input  logic        flush,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        stallreq,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

  state_t state;
  logic   i_done, d_done, i_discard;
  logic   i_pend, d_pend, grant_d;

  // A port is pending until its result is latched in the done flag.
  assign i_pend   = i_ce & ~i_done;
  assign d_pend   = d_ce & ~d_done;
  assign i_stall  = i_pend;
  assign d_stall  = d_pend;
  assign stallreq = i_pend | d_pend;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;  // 1: the data port received the most recent grant
  // On a tie, the port that was not granted last time wins.
  assign grant_d = d_pend & (~i_pend | ~last_d);
`else
  // The data port belongs to the older instruction, so it always wins.
  assign grant_d = d_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_discard <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      // The done flags release once the pipeline advances past the access.
      if (i_done & ~pipe_stall) i_done <= 1'b0;
      if (d_done & ~pipe_stall) d_done <= 1'b0;
      // A flushed fetch result no longer belongs to any instruction.
      if (flush) i_done <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUS_D;
            bus_stb   <= 1'b1;
            bus_we    <= d_we;
            bus_sel   <= d_sel;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
          end else if (i_pend) begin
            state     <= BUS_I;
            bus_stb   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'b1111;
            bus_addr  <= i_addr;
            bus_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
          end
        end
        BUS_I: begin
          if (flush) i_discard <= 1'b1;
          if (bus_ack) begin
            state     <= IDLE;
            bus_stb   <= 1'b0;
            i_discard <= 1'b0;
            // Drop the result if a flush cancelled it or the requester left.
            if (i_ce & ~i_discard & ~flush) begin
              i_done  <= 1'b1;
              i_rdata <= bus_rdata;
            end
          end
        end
        BUS_D: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_stb <= 1'b0;
            if (d_ce) begin
              d_done <= 1'b1;
              if (!bus_we) d_rdata <= bus_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. It covers reset, a table of single accesses,
// directed multi-cycle corner cases, and randomized rounds. The randomized
// rounds are checked against a transaction-level expectation.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_stall = 1'b0, flush = 1'b0;
  logic        i_ce = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_ce = 1'b0, d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_stall, stallreq;
  logic        bus_stb, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .flush(flush),
    .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall), .stallreq(stallreq),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start;
    int          ack;
  } txn_t;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   wait_n = 0;
  bit   fixed_en = 1'b0;
  logic [31:0] fixed_rd = '0;
  bit   force_ack = 1'b0;
  int   stb_cnt = 0, start_cyc = 0, n_txn = 0;
  txn_t log_q[$];
  bit   mdl_last_d = 1'b0;           // most recent grant went to data
  logic [31:0] exp_i = '0, exp_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Bus slave: acks after wait_n extra strobe cycles and logs each transaction.
  always @(posedge clk) begin : slave
    txn_t t;
    #2;
    bus_ack = 1'b0;
    if (force_ack) begin
      bus_ack   = 1'b1;
      bus_rdata = 32'h5A5A_5A5A;
    end else if (bus_stb) begin
      if (stb_cnt == 0) begin start_cyc = cyc; n_txn++; end
      if (stb_cnt == wait_n) begin
        bus_ack   = 1'b1;
        bus_rdata = fixed_en ? fixed_rd : slv_data(bus_addr);
        t.we = bus_we; t.sel = bus_sel; t.addr = bus_addr; t.wdata = bus_wdata;
        t.start = start_cyc; t.ack = cyc;
        log_q.push_back(t);
      end
      stb_cnt++;
    end else begin
      stb_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Counts stalled cycles until stallreq drops. The wait is bounded.
  task automatic wait_done(output int n, input string nm);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      n++;
      if (n > 60) break;
    end
    chk({nm, " stallreq released"}, 32'(stallreq), 32'd0);
  endtask

  task automatic release_pipe();
    tick();
    i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0; pipe_stall = 1'b0; flush = 1'b0;
    tick();
  endtask

  task automatic chk_txn(input string nm, input int idx, input txn_t e);
    if (idx < log_q.size()) begin
      chk({nm, " addr"}, log_q[idx].addr, e.addr);
      chk({nm, " we"}, 32'(log_q[idx].we), 32'(e.we));
      chk({nm, " sel"}, 32'(log_q[idx].sel), 32'(e.sel));
      if (e.we) chk({nm, " wdata"}, log_q[idx].wdata, e.wdata);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] rd;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[6];
    txn_t e, ex[$];
    int   n, dd, ii, ntx;
    bit   use_i, use_d, dwe, data_first;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dsel;
    int   kind, h;

    vt[0] = '{0, 0, 4'h0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'hF};
    vt[1] = '{1, 0, 4'hF, 32'h0000_0300, 32'h0, 1, 32'h1122_3344, 3, 32'h1122_3344, 4'hF};
    vt[2] = '{1, 1, 4'hF, 32'h0000_0200, 32'h1234_5678, 2, 32'hFFFF_0000, 4, 32'h1122_3344, 4'hF};
    vt[3] = '{1, 1, 4'h2, 32'h0000_0401, 32'h0000_CD00, 0, 32'hFFFF_0001, 2, 32'h1122_3344, 4'h2};
    vt[4] = '{1, 0, 4'hC, 32'h0000_0502, 32'h0, 3, 32'hBEEF_0000, 5, 32'hBEEF_0000, 4'hC};
    vt[5] = '{0, 0, 4'h0, 32'h0000_0104, 32'h0, 1, 32'h2402_0005, 3, 32'h2402_0005, 4'hF};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst bus_stb", 32'(bus_stb), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_sel", 32'(bus_sel), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst i_stall", 32'(i_stall), 32'd0);
    chk("rst d_stall", 32'(d_stall), 32'd0);
    chk("rst stallreq", 32'(stallreq), 32'd0);
    tick(); rst = 1'b0; mdl_last_d = 1'b0;

    // Single accesses from the vector table
    for (int v = 0; v < 6; v++) begin
      log_q.delete(); wait_n = vt[v].wt; fixed_en = 1'b1; fixed_rd = vt[v].rd;
      tick();
      pipe_stall = 1'b1;
      if (vt[v].is_d) begin
        d_ce = 1'b1; d_we = vt[v].we; d_sel = vt[v].sel;
        d_addr = vt[v].addr; d_wdata = vt[v].wdata;
      end else begin
        i_ce = 1'b1; i_addr = vt[v].addr;
      end
      wait_done(n, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d stall cycles", v), n, vt[v].exp_stall);
      chk($sformatf("vec%0d rdata", v), vt[v].is_d ? d_rdata : i_rdata, vt[v].exp_rdata);
      chk($sformatf("vec%0d txn count", v), log_q.size(), 32'd1);
      e.we = vt[v].we; e.sel = vt[v].exp_sel; e.addr = vt[v].addr; e.wdata = vt[v].wdata;
      chk_txn($sformatf("vec%0d", v), 0, e);
      if (vt[v].is_d) exp_d = vt[v].exp_rdata; else exp_i = vt[v].exp_rdata;
      mdl_last_d = vt[v].is_d;
      release_pipe();
    end

    // Simultaneous sw and fetch. The loser is issued two cycles after the winner's ack.
`ifdef ARB_ROUND_ROBIN_EN
    data_first = !mdl_last_d;
`else
    data_first = 1'b1;
`endif
    log_q.delete(); wait_n = 2; fixed_en = 1'b1; fixed_rd = 32'h8C82_0000;
    tick();
    pipe_stall = 1'b1;
    d_ce = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    i_ce = 1'b1; i_addr = 32'h104;
    dd = 0; ii = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!d_stall && dd == 0) dd = k;
      if (!i_stall && ii == 0) ii = k;
      if (dd != 0 && ii != 0) break;
    end
    chk("simul winner stall drop", data_first ? dd : ii, 32'd5);
    chk("simul loser stall drop", data_first ? ii : dd, 32'd9);
    chk("simul txn count", log_q.size(), 32'd2);
    e.we = 1'b1; e.sel = 4'hF; e.addr = 32'h200; e.wdata = 32'h1234_5678;
    chk_txn("simul data", data_first ? 0 : 1, e);
    e.we = 1'b0; e.sel = 4'hF; e.addr = 32'h104;
    chk_txn("simul fetch", data_first ? 1 : 0, e);
    if (log_q.size() == 2) chk("simul second issue gap", log_q[1].start, log_q[0].ack + 2);
    chk("simul i_rdata", i_rdata, 32'h8C82_0000);
    exp_i = 32'h8C82_0000;
    mdl_last_d = !data_first;
    release_pipe();

    // Completed fetch held by pipe_stall for 3 cycles
    log_q.delete(); wait_n = 0; fixed_rd = 32'h1357_9BDF;
    tick();
    pipe_stall = 1'b1; i_ce = 1'b1; i_addr = 32'h180;
    wait_done(n, "hold");
    exp_i = 32'h1357_9BDF; mdl_last_d = 1'b0;
    ntx = n_txn;
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      chk($sformatf("hold%0d i_stall", k), 32'(i_stall), 32'd0);
      chk($sformatf("hold%0d i_rdata", k), i_rdata, exp_i);
    end
    chk("hold no reissue", n_txn, ntx);
    release_pipe();

    // Flush in the second BUS_I cycle, ack three cycles later
    log_q.delete(); wait_n = 3; fixed_rd = 32'hAAAA_5555;
    tick(); pipe_stall = 1'b1; i_ce = 1'b1; i_addr = 32'h1C0;  // T
    tick();                                                    // T+1
    tick(); flush = 1'b1;                                      // T+2
    tick(); flush = 1'b0;                                      // T+3
    tick();                                                    // T+4 ack
    tick(); fixed_rd = 32'h0BAD_F00D;                          // T+5
    @(negedge clk);
    chk("flush i_stall kept", 32'(i_stall), 32'd1);
    chk("flush i_rdata kept", i_rdata, exp_i);
    chk("flush txn logged", log_q.size(), 32'd1);
    wait_done(n, "flush refetch");
    chk("flush refetch data", i_rdata, 32'h0BAD_F00D);
    chk("flush refetch count", log_q.size(), 32'd2);
    if (log_q.size() == 2) chk("flush refetch addr", log_q[1].addr, 32'h1C0);
    exp_i = 32'h0BAD_F00D;
    release_pipe();

    // Flush in the same cycle as the ack
    log_q.delete(); wait_n = 0; fixed_rd = 32'hAAAA_5555;
    tick(); pipe_stall = 1'b1; i_ce = 1'b1; i_addr = 32'h1E0;  // T
    tick(); flush = 1'b1;                                      // T+1 ack
    tick(); flush = 1'b0; fixed_rd = 32'h3C3C_0F0F;            // T+2
    @(negedge clk);
    chk("flush+ack i_stall kept", 32'(i_stall), 32'd1);
    chk("flush+ack i_rdata kept", i_rdata, exp_i);
    wait_done(n, "flush+ack refetch");
    chk("flush+ack refetch data", i_rdata, 32'h3C3C_0F0F);
    exp_i = 32'h3C3C_0F0F;
    release_pipe();

    // Data requester drops d_ce mid-transaction
    log_q.delete(); wait_n = 2; fixed_rd = 32'h7777_7777;
    tick(); pipe_stall = 1'b1; d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h600;
    tick(); d_ce = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("drop d_rdata kept", d_rdata, exp_d);
    chk("drop d_stall", 32'(d_stall), 32'd0);
    chk("drop txn completed", log_q.size(), 32'd1);
    mdl_last_d = 1'b1;
    release_pipe();

    // bus_ack while IDLE
    ntx = log_q.size();
    tick(); force_ack = 1'b1;
    tick(); force_ack = 1'b0;
    tick();
    @(negedge clk);
    chk("idle ack i_rdata", i_rdata, exp_i);
    chk("idle ack d_rdata", d_rdata, exp_d);
    chk("idle ack bus_stb", 32'(bus_stb), 32'd0);
    chk("idle ack stallreq", 32'(stallreq), 32'd0);

    // Reset during BUS_D, then a sb completes normally
    wait_n = 5;
    tick(); pipe_stall = 1'b1; d_ce = 1'b1; d_we = 1'b1; d_sel = 4'hF;
    d_addr = 32'h700; d_wdata = 32'hFEED_FACE;
    tick();
    tick(); rst = 1'b1; d_ce = 1'b0; d_we = 1'b0; pipe_stall = 1'b0;
    tick();
    @(negedge clk);
    chk("mid rst bus_stb", 32'(bus_stb), 32'd0);
    chk("mid rst bus_we", 32'(bus_we), 32'd0);
    chk("mid rst bus_sel", 32'(bus_sel), 32'd0);
    chk("mid rst bus_addr", bus_addr, 32'd0);
    chk("mid rst bus_wdata", bus_wdata, 32'd0);
    chk("mid rst i_rdata", i_rdata, 32'd0);
    chk("mid rst d_rdata", d_rdata, 32'd0);
    chk("mid rst stallreq", 32'(stallreq), 32'd0);
    tick(); rst = 1'b0; exp_i = '0; exp_d = '0; mdl_last_d = 1'b0;
    log_q.delete(); wait_n = 0;
    tick(); pipe_stall = 1'b1; d_ce = 1'b1; d_we = 1'b1; d_sel = 4'b0100;
    d_addr = 32'h403; d_wdata = 32'h00AB_0000;
    wait_done(n, "post rst sb");
    chk("post rst sb stall cycles", n, 32'd2);
    chk("post rst sb count", log_q.size(), 32'd1);
    e.we = 1'b1; e.sel = 4'b0100; e.addr = 32'h403; e.wdata = 32'h00AB_0000;
    chk_txn("post rst sb", 0, e);
    chk("post rst sb d_rdata", d_rdata, 32'd0);
    mdl_last_d = 1'b1;
    release_pipe();

    // Randomized rounds against a transaction-level expectation
    fixed_en = 1'b0;
    for (int r = 0; r < 40; r++) begin
      kind  = $urandom_range(0, 2);
      use_i = (kind != 1);
      use_d = (kind != 0);
      ia    = $urandom & 32'hFFFF_FFFC;
      da    = $urandom;
      dwe   = 1'($urandom_range(0, 1));
      dsel  = 4'($urandom_range(1, 15));
      dwd   = $urandom;
      wait_n = $urandom_range(0, 3);
      log_q.delete();
      tick();
      pipe_stall = 1'b1;
      if (use_i) begin i_ce = 1'b1; i_addr = ia; end
      if (use_d) begin d_ce = 1'b1; d_we = dwe; d_sel = dsel; d_addr = da; d_wdata = dwd; end
      @(negedge clk);
      chk($sformatf("rnd%0d stall asserted", r), 32'(stallreq), 32'd1);
      wait_done(n, $sformatf("rnd%0d", r));

`ifdef ARB_ROUND_ROBIN_EN
      data_first = !mdl_last_d;
`else
      data_first = 1'b1;
`endif
      ex.delete();
      if (use_d && (data_first || !use_i)) begin
        e.we = dwe; e.sel = dsel; e.addr = da; e.wdata = dwd; ex.push_back(e);
      end
      if (use_i) begin
        e.we = 1'b0; e.sel = 4'hF; e.addr = ia; e.wdata = '0; ex.push_back(e);
      end
      if (use_d && use_i && !data_first) begin
        e.we = dwe; e.sel = dsel; e.addr = da; e.wdata = dwd; ex.push_back(e);
      end
      chk($sformatf("rnd%0d txn count", r), log_q.size(), ex.size());
      foreach (ex[j]) chk_txn($sformatf("rnd%0d txn%0d", r, j), j, ex[j]);
      mdl_last_d = (ex[ex.size()-1].we == dwe && use_d && !(use_i && !data_first)) ? 1'b1 : 1'b0;
      if (use_i && use_d) mdl_last_d = !data_first;
      else mdl_last_d = use_d;

      if (use_i) exp_i = slv_data(ia);
      if (use_d && !dwe) exp_d = slv_data(da);
      chk($sformatf("rnd%0d i_rdata", r), i_rdata, exp_i);
      chk($sformatf("rnd%0d d_rdata", r), d_rdata, exp_d);

      h = $urandom_range(0, 2);
      ntx = n_txn;
      repeat (h) tick();
      @(negedge clk);
      chk($sformatf("rnd%0d held no reissue", r), n_txn, ntx);
      chk($sformatf("rnd%0d held stallreq", r), 32'(stallreq), 32'd0);
      release_pipe();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates one shared synchronous memory bus between the pipeline's instruction-fetch port and the MEM stage's data port, which issues lb/lh/lw/lwl/lwr/ll/sb/sh/sw/swl/swr/sc accesses.
- Sequences each request into a single registered bus transaction and stalls the requester until the transaction completes.
- Holds completed read data stable while the pipeline is frozen.
- Absorbs fetch results cancelled by a pipeline flush.
- Sits between the IF/MEM stages and the external memory/bus bridge. Also drives the stall-request input of the pipeline controller.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- pipe_stall  in  1  pipeline is held this cycle (from controller)
- flush  in  1  pipeline flush; cancels the instruction fetch
- i_ce  in  1  fetch request (level, held until i_stall low)
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched word
- i_stall  out  1  fetch not yet complete
- d_ce  in  1  data request (level)
- d_we  in  1  data write
- d_sel  in  4  byte enables; bit3 = bits 31:24
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_stall  out  1  data access not yet complete
- stallreq  out  1  i_stall | d_stall
- bus_stb  out  1  transaction strobe (registered)
- bus_we  out  1  write
- bus_sel  out  4  byte enables (fetch: 4'b1111)
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete, one cycle

## Operation
- States: IDLE, BUS_I, BUS_D.
- **IDLE:**
  - Pending fetch = i_ce & !i_done. Pending data = d_ce & !d_done.
  - Pick a winner, register the bus outputs from the winner's inputs and go to BUS_I or BUS_D.
  - No pending request: stay in IDLE with bus_stb = 0.
- **BUS_x:**
  - bus_* outputs are held constant.
  - On bus_ack: bus_stb drops next cycle, set x_done and return to IDLE.
  - Read: capture bus_rdata into x_rdata. Write: d_rdata is unchanged.
- **Stall rule:**
  - i_stall = i_ce & !i_done; d_stall = d_ce & !d_done (combinational).
  - x_done clears on the first edge where x_done = 1 and pipe_stall = 0, i.e. the pipeline advances.
  - While pipe_stall = 1, x_done and x_rdata are held, so a completed access is never reissued.
- **Priority:** with both pending in IDLE, the data port wins (older instruction).
- **Flush:**
  - On flush, i_done clears.
  - If state is BUS_I, set i_discard. The transaction completes on the bus, then bus_ack returns to IDLE without setting i_done or updating i_rdata.
  - i_discard clears on that ack.
  - Flush does not affect the data port.
- **Boundaries:**
  - Requester drops ce during BUS_x: the transaction still completes; the result is dropped (done not set).
  - bus_ack in IDLE is ignored.
  - flush and bus_ack in the same cycle in BUS_I: the result is discarded.
- **Reset:**
  - State returns to IDLE. All outputs are 0, including i_rdata and d_rdata.
  - done and discard flags are 0.
  - A bus transaction in flight is abandoned (bus_stb low next cycle); slaves must tolerate this.

## Timing
- Request seen in IDLE at cycle T: bus_stb = 1 from T+1.
- Ack at cycle A ≥ T+1: x_stall = 1 through A, low from A+1, with x_rdata valid from A+1.
- Zero-wait slave: 2 stall cycles per access.
- A fetch and a data access requested together: the data access is acked at A1, the fetch is issued at A1+2 (one IDLE cycle between).

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous pending requests, the port not granted most recently wins. A 1-bit last-grant register, reset to fetch, is updated at each grant.
- Undefined: fixed data-over-fetch priority, and no last-grant register exists.

## Test plan
- **Fetch alone, zero-wait slave:** i_ce = 1, addr 0x100, bus_rdata 0xDEADBEEF acked in the first stb cycle → i_stall high for 2 cycles, then i_rdata = 0xDEADBEEF, stallreq = 0.
- **Simultaneous requests, fixed priority:** sw 0x12345678 to 0x200 with fetch 0x104, 2-wait slave → data transaction first (bus_we = 1, sel 4'b1111), fetch issued 2 cycles after the data ack; d_stall drops before i_stall.
- **ARB_ROUND_ROBIN_EN:** two back-to-back simultaneous-pending rounds → grant order fetch, data, fetch, data.
- **pipe_stall hold:** complete a fetch while pipe_stall = 1 for 3 cycles → i_stall stays 0, i_rdata stable, no second bus_stb.
- **Flush mid-fetch:** flush at the second BUS_I cycle, ack 0xAAAA5555 → i_rdata unchanged, i_done = 0; the next i_ce starts a new transaction.
- **Reset mid-transaction:** rst during BUS_D → next cycle bus_stb = 0, all outputs 0, state IDLE; a following sb with sel 4'b0100 completes normally.
